// File: rtl/aes_pkg.sv
// Shared AES definitions: forward and inverse S-box tables, state type and engine FSM encoding.
package aes_pkg;

    localparam int NUM_BYTES = 16;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } engine_state_t;

    // Entry [0] sits in the most significant byte of each table literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane; inv selects the inverse table.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] data,
    input  logic       inv,
    output logic [7:0] result
);

    assign result = inv ? INV_SBOX[data] : SBOX[data];

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes: LANES S-boxes walk the captured state over 16/LANES passes.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int NPASS = (LANES > 0) ? (NUM_BYTES / LANES) : 1;
    localparam int CNT_W = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPASS - 1);

    if ((LANES < 1) || (LANES > NUM_BYTES) || ((NUM_BYTES % LANES) != 0)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    engine_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             mode;
    aes_state_t       captured;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    // Only DONE lets out_ready reach in_ready, so a drained result can overlap the next accept.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = captured[127 - 8 * (LANES * int'(cnt) + l) -: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_lane u_lane (
            .data   (lane_in[g]),
            .inv    (mode),
            .result (lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            captured  <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        captured <= in_state;
                        mode     <= in_inv;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        out_state[127 - 8 * (LANES * int'(cnt) + l) -: 8] <= lane_out[l];
                    end
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            captured <= in_state;
                            mode     <= in_inv;
                            cnt      <= '0;
                            state    <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine at LANES = 1, 4 and 16 against a GF(2^8) arithmetic model of SubBytes.
module tb_sub_bytes_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_inv    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int checks   = 0;
    int failures = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] expected;
    } vec_t;

    vec_t vecs[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        sub_bytes_engine #(.LANES(L)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g])
        );
    end

    function automatic int npass(int k);
        return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_model(logic [7:0] x);
        logic [7:0] b = 8'h01;
        logic [7:0] r;
        logic [7:0] acc;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        r   = b;
        acc = b;
        for (int i = 0; i < 4; i++) begin
            r   = {r[6:0], r[7]};
            acc = acc ^ r;
        end
        return acc ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_sub(logic [127:0] din, logic inv);
        logic [127:0] res = '0;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = din[127 - 8 * i -: 8];
            res[127 - 8 * i -: 8] = inv ? inv_tab[b] : fwd_tab[b];
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(string name, logic [127:0] actual, logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Drive a request on DUT k and return at #1 after the edge that accepted it.
    task automatic applyStimulus(int k, logic [127:0] din, logic inv, string name);
        bit ok = 0;
        in_valid[k] = 1'b1;
        in_state[k] = din;
        in_inv[k]   = inv;
        for (int c = 0; c < 50; c++) begin
            if (in_ready[k]) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid[k] = 1'b0;
        if (!ok) timeoutFail({name, "_accept"});
    endtask

    task automatic waitOutput(int k, output int cycles);
        cycles = 0;
        while (!out_valid[k] && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic runVector(int k, vec_t v, string name);
        int cycles;
        out_ready[k] = 1'b1;
        applyStimulus(k, v.din, v.inv, name);
        waitOutput(k, cycles);
        if (!out_valid[k]) timeoutFail({name, "_done"});
        checkOutput({name, "_latency"}, 128'(cycles), 128'(npass(k)));
        checkOutput({name, "_data"}, out_state[k], v.expected);
        @(posedge clk); #1;
        checkOutput({name, "_drained"}, 128'(out_valid[k]), 128'(0));
        checkOutput({name, "_idle_ready"}, 128'(in_ready[k]), 128'(1));
    endtask

    task automatic backpressure(int k);
        logic [127:0] a = rand128();
        logic [127:0] b = rand128();
        logic [127:0] held;
        int cycles;
        out_ready[k] = 1'b0;
        applyStimulus(k, a, 1'b0, "bp_first");
        waitOutput(k, cycles);
        if (!out_valid[k]) timeoutFail("bp_first_done");
        held = out_state[k];
        checkOutput("bp_first_data", held, model_sub(a, 1'b0));
        in_valid[k] = 1'b1;
        in_state[k] = b;
        in_inv[k]   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_stable", out_state[k], held);
            checkOutput("bp_valid", 128'(out_valid[k]), 128'(1));
            checkOutput("bp_in_ready", 128'(in_ready[k]), 128'(0));
            @(posedge clk); #1;
        end
        out_ready[k] = 1'b1;
        #1;
        checkOutput("bp_release_ready", 128'(in_ready[k]), 128'(1));
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        checkOutput("bp_valid_drop", 128'(out_valid[k]), 128'(0));
        waitOutput(k, cycles);
        if (!out_valid[k]) timeoutFail("bp_second_done");
        checkOutput("bp_second_latency", 128'(cycles), 128'(npass(k)));
        checkOutput("bp_second_data", out_state[k], model_sub(b, 1'b1));
        @(posedge clk); #1;
    endtask

    // Three transactions streamed with in_valid and out_ready held high; in_inv moves during BUSY.
    task automatic backToBack();
        logic [127:0] st [3];
        logic         md [3];
        int           out_cyc [3];
        int           idx_in = 0;
        int           n_out  = 0;
        bit           acc;
        for (int i = 0; i < 3; i++) begin
            st[i] = rand128();
            md[i] = (i == 1);
        end
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_state[1]  = st[0];
        in_inv[1]    = md[0];
        for (int cyc = 0; cyc < 60 && n_out < 3; cyc++) begin
            acc = in_valid[1] && in_ready[1];
            if (out_valid[1]) begin
                checkOutput("b2b_data", out_state[1], model_sub(st[n_out], md[n_out]));
                out_cyc[n_out] = cyc;
                n_out++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 3) begin
                    in_state[1] = st[idx_in];
                    in_inv[1]   = md[idx_in];
                end else begin
                    in_valid[1] = 1'b0;
                end
            end
        end
        in_valid[1] = 1'b0;
        if (n_out < 3) begin
            timeoutFail("b2b_outputs");
        end else begin
            checkOutput("b2b_first_latency", 128'(out_cyc[0]), 128'(5));
            checkOutput("b2b_period_1", 128'(out_cyc[1] - out_cyc[0]), 128'(5));
            checkOutput("b2b_period_2", 128'(out_cyc[2] - out_cyc[1]), 128'(5));
        end
        @(posedge clk); #1;
    endtask

    task automatic resetMidBusy(int k);
        vec_t v;
        applyStimulus(k, rand128(), 1'b0, "rst_busy");
        repeat (npass(k) / 2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 128'(out_valid[k]), 128'(0));
        checkOutput("rst_in_ready", 128'(in_ready[k]), 128'(1));
        checkOutput("rst_out_state", out_state[k], 128'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v.din      = rand128();
        v.inv      = 1'b1;
        v.expected = model_sub(v.din, v.inv);
        runVector(k, v, "rst_fresh");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_model(8'(x));
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        vecs.push_back('{128'h3243f6a8885a308d313198a2e0370734, 1'b0, 128'h231a42c2c4be045dc7c7463ae19ac518});
        vecs.push_back('{128'h231a42c2c4be045dc7c7463ae19ac518, 1'b1, 128'h3243f6a8885a308d313198a2e0370734});
        vecs.push_back('{128'h0, 1'b0, {16{8'h63}}});
        vecs.push_back('{{16{8'h63}}, 1'b1, 128'h0});
        for (int i = 0; i < 6; i++) begin
            v.din      = rand128();
            v.inv      = 1'($urandom_range(0, 1));
            v.expected = model_sub(v.din, v.inv);
            vecs.push_back(v);
        end

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_inv[k]    = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_in_ready", 128'(in_ready[k]), 128'(1));
            checkOutput("reset_out_valid", 128'(out_valid[k]), 128'(0));
            checkOutput("reset_out_state", out_state[k], 128'h0);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) begin
            $display("[TB] vector table on DUT %0d (NPASS=%0d)", k, npass(k));
            foreach (vecs[i]) runVector(k, vecs[i], $sformatf("vec%0d_dut%0d", i, k));
        end

        for (int k = 0; k < 3; k++) backpressure(k);
        backToBack();
        resetMidBusy(0);
        resetMidBusy(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
